// File: rtl/tri_bus_arbiter.sv
// rtl/tri_bus_arbiter.sv - round-robin, break-before-make arbiter for TRIGATEX4 tristate bus drivers.
// Optional hold-limit preemption is enabled by defining TRI_ARB_TIMEOUT_EN.
module tri_bus_arbiter #(
   parameter int NREQ     = 4,
   parameter int HOLD_MAX = 8,
   parameter int CW       = 8
) (
   input  logic            CLK,
   input  logic            RSTN,
   input  logic [NREQ-1:0] REQ,
   output logic [NREQ-1:0] EN,
   output logic [NREQ-1:0] GNT,
   output logic            BUSY,
   output logic            TURN,
   output logic [2:0]      OWNER
);

   localparam int IW = $clog2(NREQ);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_TURN  = 2'd2
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [NREQ-1:0] r_en, w_en_nxt;
   logic [2:0]      r_owner, w_owner_nxt;
   logic [IW-1:0]   r_last, w_last_nxt;
   logic [IW-1:0]   w_idx, w_winner;
   logic [NREQ-1:0] w_grant;
   logic            w_any;
   logic            w_timeout;
   logic            w_release;

   generate
      if (NREQ < 2 || NREQ > 8 || HOLD_MAX < 1 || HOLD_MAX > 255 || HOLD_MAX >= (1 << CW)) begin : g_bad_cfg
         $error("tri_bus_arbiter: illegal NREQ/HOLD_MAX/CW combination");
      end
   endgenerate

   // Rotating search beginning just after the previous owner.
   always_comb begin
      w_idx    = r_last;
      w_winner = r_last;
      w_any    = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         w_idx = (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
         if (!w_any && REQ[w_idx]) begin
            w_any    = 1'b1;
            w_winner = w_idx;
         end
      end
   end

   assign w_grant = NREQ'(1) << w_winner;

`ifdef TRI_ARB_TIMEOUT_EN
   logic [CW-1:0] r_cnt, w_cnt_nxt;

   assign w_timeout = (r_cnt == CW'(HOLD_MAX - 1));

   always_comb begin
      w_cnt_nxt = '0;
      if (r_state == S_DRIVE && !w_release && r_cnt != '1) begin
         w_cnt_nxt = r_cnt + 1'b1;
      end else if (r_state == S_DRIVE && !w_release) begin
         w_cnt_nxt = r_cnt;
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   // While driving, r_last always equals the owner index.
   assign w_release = !REQ[r_last] || w_timeout;

   always_comb begin
      w_state_nxt = r_state;
      w_en_nxt    = r_en;
      w_owner_nxt = r_owner;
      w_last_nxt  = r_last;
      case (r_state)
         S_IDLE, S_TURN: begin
            if (w_any) begin
               w_state_nxt = S_DRIVE;
               w_en_nxt    = w_grant;
               w_owner_nxt = 3'(w_winner);
               w_last_nxt  = w_winner;
            end else begin
               w_state_nxt = S_IDLE;
               w_en_nxt    = '0;
            end
         end
         S_DRIVE: begin
            if (w_release) begin
               w_state_nxt = S_TURN;
               w_en_nxt    = '0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_en_nxt    = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_state <= S_IDLE;
         r_en    <= '0;
         r_owner <= '0;
         r_last  <= IW'(NREQ - 1);
      end else begin
         r_state <= w_state_nxt;
         r_en    <= w_en_nxt;
         r_owner <= w_owner_nxt;
         r_last  <= w_last_nxt;
      end
   end

   assign EN    = r_en;
   assign GNT   = r_en;
   assign BUSY  = (r_state == S_DRIVE);
   assign TURN  = (r_state == S_TURN);
   assign OWNER = r_owner;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// tb/tb_tri_bus_arbiter.sv - scoreboard bench for tri_bus_arbiter with directed request vectors.
module tb_tri_bus_arbiter;

   localparam int NREQ = 4;

   logic            CLK  = 1'b0;
   logic            RSTN = 1'b0;
   logic [NREQ-1:0] REQ  = '0;
   logic [NREQ-1:0] EN;
   logic [NREQ-1:0] GNT;
   logic            BUSY;
   logic            TURN;
   logic [2:0]      OWNER;

   tri_bus_arbiter #(.NREQ(NREQ), .HOLD_MAX(8), .CW(8)) u_dut (
      .CLK   (CLK),
      .RSTN  (RSTN),
      .REQ   (REQ),
      .EN    (EN),
      .GNT   (GNT),
      .BUSY  (BUSY),
      .TURN  (TURN),
      .OWNER (OWNER)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [3:0] en;
      logic       turn;
      logic [2:0] owner;
      string      name;
   } exp_t;

   exp_t  sbq[$];
   string tname = "reset";
   int    n_tests = 0;
   int    n_fail  = 0;

   task automatic step(input logic [3:0] req, input logic [3:0] en, input logic turn, input logic [2:0] owner);
      exp_t e;
      @(posedge CLK);
      #1;
      REQ     = req;
      e.cyc   = cyc + 1;
      e.en    = en;
      e.turn  = turn;
      e.owner = owner;
      e.name  = tname;
      sbq.push_back(e);
   endtask

   initial begin
      fork
         begin : mon
            exp_t e;
            forever begin
               @(negedge CLK);
               if (RSTN) begin
                  n_tests++;
                  if (!($countones(EN) <= 1 && EN == GNT && BUSY == (|EN) && !(BUSY && TURN))) begin
                     n_fail++;
                     $display("FAIL invariant cyc=%0d EN=%b GNT=%b BUSY=%b TURN=%b", cyc, EN, GNT, BUSY, TURN);
                  end
                  while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                     e = sbq.pop_front();
                     n_tests++;
                     if (e.cyc != cyc || EN !== e.en || GNT !== e.en || TURN !== e.turn ||
                         OWNER !== e.owner || BUSY !== (|e.en)) begin
                        n_fail++;
                        $display("FAIL %s cyc=%0d got EN=%b TURN=%b OWNER=%0d BUSY=%b want EN=%b TURN=%b OWNER=%0d (slot %0d)",
                                 e.name, cyc, EN, TURN, OWNER, BUSY, e.en, e.turn, e.owner, e.cyc);
                     end
                  end
               end
            end
         end
         begin : stim
            int order[5];
            int drain;
            logic [3:0] oh;
            order = '{0, 1, 2, 3, 0};

            RSTN = 1'b0;
            REQ  = '0;
            repeat (3) @(posedge CLK);
            #1;
            n_tests++;
            if (EN !== 4'b0 || GNT !== 4'b0 || BUSY !== 1'b0 || TURN !== 1'b0 || OWNER !== 3'd0) begin
               n_fail++;
               $display("FAIL reset_state got EN=%b GNT=%b BUSY=%b TURN=%b OWNER=%0d want all zero",
                        EN, GNT, BUSY, TURN, OWNER);
            end
            RSTN = 1'b1;

            tname = "idle";
            repeat (10) step(4'b0000, 4'b0000, 1'b0, 3'd0);

            tname = "req0101";
            step(4'b0101, 4'b0001, 1'b0, 3'd0);
            step(4'b0101, 4'b0001, 1'b0, 3'd0);
            step(4'b0100, 4'b0000, 1'b1, 3'd0);
            step(4'b0100, 4'b0100, 1'b0, 3'd2);
            step(4'b0000, 4'b0000, 1'b1, 3'd2);
            step(4'b0000, 4'b0000, 1'b0, 3'd2);

            tname = "pulse3";
            step(4'b1000, 4'b1000, 1'b0, 3'd3);
            step(4'b0000, 4'b0000, 1'b1, 3'd3);
            step(4'b0000, 4'b0000, 1'b0, 3'd3);
            step(4'b0000, 4'b0000, 1'b0, 3'd3);

            tname = "rr1111";
            for (int k = 0; k < 5; k++) begin
               oh = 4'(1) << order[k];
               repeat (3) step(4'b1111, oh, 1'b0, 3'(order[k]));
               if (k < 4) step(4'b1111 & ~oh, 4'b0000, 1'b1, 3'(order[k]));
            end
            step(4'b0000, 4'b0000, 1'b1, 3'd0);
            step(4'b0000, 4'b0000, 1'b0, 3'd0);

            tname = "hold1_req2";
`ifdef TRI_ARB_TIMEOUT_EN
            repeat (8) step(4'b0110, 4'b0010, 1'b0, 3'd1);
            step(4'b0110, 4'b0000, 1'b1, 3'd1);
            step(4'b0110, 4'b0100, 1'b0, 3'd2);
`else
            repeat (12) step(4'b0110, 4'b0010, 1'b0, 3'd1);
            step(4'b0100, 4'b0000, 1'b1, 3'd1);
            step(4'b0100, 4'b0100, 1'b0, 3'd2);
`endif
            step(4'b0000, 4'b0000, 1'b1, 3'd2);
            step(4'b0000, 4'b0000, 1'b0, 3'd2);

            tname = "solo0";
            for (int i = 0; i < 30; i++) begin
`ifdef TRI_ARB_TIMEOUT_EN
               if (i % 9 == 8) step(4'b0001, 4'b0000, 1'b1, 3'd0);
               else            step(4'b0001, 4'b0001, 1'b0, 3'd0);
`else
               step(4'b0001, 4'b0001, 1'b0, 3'd0);
`endif
            end
            step(4'b0000, 4'b0000, 1'b1, 3'd0);
            step(4'b0000, 4'b0000, 1'b0, 3'd0);

            tname = "grant1";
            step(4'b0010, 4'b0010, 1'b0, 3'd1);
            @(posedge CLK);
            @(negedge CLK);
            #1;
            REQ  = '0;
            RSTN = 1'b0;
            #1;
            n_tests++;
            if (EN !== 4'b0 || GNT !== 4'b0 || BUSY !== 1'b0 || TURN !== 1'b0 || OWNER !== 3'd0) begin
               n_fail++;
               $display("FAIL async_reset got EN=%b GNT=%b BUSY=%b TURN=%b OWNER=%0d want all zero",
                        EN, GNT, BUSY, TURN, OWNER);
            end
            @(posedge CLK);
            #3;
            RSTN = 1'b1;

            tname = "post_reset";
            step(4'b1001, 4'b0001, 1'b0, 3'd0);
            step(4'b0000, 4'b0000, 1'b1, 3'd0);
            step(4'b0000, 4'b0000, 1'b0, 3'd0);

            drain = 0;
            while (sbq.size() != 0 && drain < 20) begin
               @(negedge CLK);
               #1;
               drain++;
            end
            n_tests++;
            if (sbq.size() != 0) begin
               n_fail++;
               $display("FAIL drain got %0d pending entries want 0", sbq.size());
            end
         end
      join_any
      disable fork;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
